falafel_mem_cas_ctrl: RTL



---
 rtl/falafel_mem_cas_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/falafel_mem_cas_ctrl.sv
// Memory-side request servicer for the falafel LSU: load / store / compare-and-swap against an on-chip word array.
// Optional out-of-range address trapping is enabled by defining FALAFEL_MEM_BOUNDS_CHECK_EN.
module falafel_mem_cas_ctrl #(
    parameter int                DATA_W        = 32,
    parameter int                DEPTH         = 1024,
    parameter logic [DATA_W-1:0] EMPTY_KEY     = 32'hFFFF_FFFF,
    parameter logic [DATA_W-1:0] CAS_FAIL_DATA = 32'h0000_0001
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_req_val_i,
    output logic              mem_req_rdy_o,
    input  logic              mem_req_is_write_i,
    input  logic              mem_req_is_cas_i,
    input  logic [DATA_W-1:0] mem_req_addr_i,
    input  logic [DATA_W-1:0] mem_req_data_i,
    output logic              mem_rsp_val_o,
    input  logic              mem_rsp_rdy_i,
    output logic [DATA_W-1:0] mem_rsp_data_o,
    output logic              busy_o
`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
   ,output logic              oob_err_o
`endif
);

    localparam int OFF_W   = $clog2(DATA_W / 8);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int IDX_MSB = IDX_W + OFF_W - 1;
    localparam logic [DATA_W-1:0] OOB_DATA = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EXEC = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_CAS   = 2'd2
    } op_t;

    state_t              state_r;
    op_t                 op_r;
    logic [IDX_W-1:0]    idx_r;
    logic [DATA_W-1:0]   data_r;
    logic                req_oob_r;
    logic [DATA_W-1:0]   rd_data_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic                rsp_val_r;
    logic                rdy_r;
    logic                busy_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                accept_s;
    op_t                 req_op_s;
    logic                req_oob_s;
    logic                cas_hit_s;
    logic                mem_we_s;
    logic                addr_unused_s;

`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
    logic                oob_err_r;

    assign req_oob_s     = |mem_req_addr_i[DATA_W-1:IDX_MSB+1];
    assign addr_unused_s = ^mem_req_addr_i[OFF_W-1:0];
    assign oob_err_o     = oob_err_r;

    // Sticky out-of-range flag, set on the accept cycle of a bad address.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            oob_err_r <= 1'b0;
        end else if (accept_s && req_oob_s) begin
            oob_err_r <= 1'b1;
        end else begin
            oob_err_r <= oob_err_r;
        end
    end
`else
    // Upper address bits are dropped: addresses wrap modulo DEPTH.
    assign req_oob_s     = 1'b0;
    assign addr_unused_s = ^{mem_req_addr_i[DATA_W-1:IDX_MSB+1], mem_req_addr_i[OFF_W-1:0]};
`endif

    // Request decode and array write-enable generation.
    always_comb begin
        accept_s  = mem_req_val_i & rdy_r;
        cas_hit_s = (rd_data_r == EMPTY_KEY);
        mem_we_s  = 1'b0;
        if (mem_req_is_cas_i) begin
            req_op_s = OP_CAS;
        end else if (mem_req_is_write_i) begin
            req_op_s = OP_STORE;
        end else begin
            req_op_s = OP_LOAD;
        end
        // Stores commit in RD; a CAS commits in EXEC only after a successful compare.
        case (state_r)
            ST_RD:   mem_we_s = (op_r == OP_STORE) && !req_oob_r;
            ST_EXEC: mem_we_s = (op_r == OP_CAS) && cas_hit_s && !req_oob_r;
            default: mem_we_s = 1'b0;
        endcase
    end

    // Word array: synchronous read of the latched index, write at the clock edge.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_r[idx_r] <= data_r;
        end
        rd_data_r <= mem_r[idx_r];
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            op_r       <= OP_LOAD;
            idx_r      <= '0;
            data_r     <= '0;
            req_oob_r  <= 1'b0;
            rsp_data_r <= '0;
            rsp_val_r  <= 1'b0;
            rdy_r      <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r      <= req_op_s;
                        idx_r     <= mem_req_addr_i[IDX_MSB:OFF_W];
                        data_r    <= mem_req_data_i;
                        req_oob_r <= req_oob_s;
                        rdy_r     <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_RD;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (req_oob_r) begin
                        rsp_data_r <= OOB_DATA;
                    end else begin
                        case (op_r)
                            OP_LOAD:  rsp_data_r <= rd_data_r;
                            OP_STORE: rsp_data_r <= data_r;
                            OP_CAS:   rsp_data_r <= cas_hit_s ? {DATA_W{1'b0}} : CAS_FAIL_DATA;
                            default:  rsp_data_r <= {DATA_W{1'b0}};
                        endcase
                    end
                    rsp_val_r <= 1'b1;
                    state_r   <= ST_RSP;
                end
                ST_RSP: begin
                    if (mem_rsp_rdy_i) begin
                        rsp_val_r <= 1'b0;
                        rdy_r     <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_RSP;
                    end
                end
                default: begin
                    rsp_val_r <= 1'b0;
                    rdy_r     <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req_rdy_o  = rdy_r;
    assign mem_rsp_val_o  = rsp_val_r;
    assign mem_rsp_data_o = rsp_data_r;
    assign busy_o         = busy_r;

endmodule
